// File: rtl/multdiv_sequencer.sv
// Sequencer between the DX stage and the iterative multiply/divide unit: accepts a
// mul/div, pulses the unit's start control, stalls until done, then commits via the write port.
//
//   state  | meaning
//   IDLE   | no op in flight; accept a mul/div from DX
//   ISSUE  | operands registered; start pulse high for this cycle only
//   WAIT   | counting cycles until the unit is ready or the timeout expires
//   COMMIT | requesting the register-file write port until granted
module multdiv_sequencer #(
  parameter int RSTATUS_REG  = 30,
  parameter int MUL_EXC_CODE = 4,
  parameter int DIV_EXC_CODE = 5,
  parameter int TIMEOUT      = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [31:0] insn_dx,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_req,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  input  logic        wb_grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [4:0]  destReg;
  logic        opIsDiv;
  logic [7:0]  waitCount;

  logic        isMul;
  logic        isDiv;
  logic        accept;
  logic        timedOut;
  logic        waitDone;
  logic        doneExc;
  logic        skipCommit;
  logic        unusedInsnBits;

  assign isMul  = (insn_dx[31:27] == 5'd0) && (insn_dx[6:2] == 5'd6);
  assign isDiv  = (insn_dx[31:27] == 5'd0) && (insn_dx[6:2] == 5'd7);
  assign accept = issue_valid && (isMul || isDiv);

  // Only opcode and destination fields matter here.
  assign unusedInsnBits = ^{insn_dx[21:7], insn_dx[1:0]};

  // A ready result in the last allowed WAIT cycle beats the timeout.
  assign timedOut   = waitCount >= 8'(TIMEOUT - 1);
  assign waitDone   = md_resultRDY || timedOut;
  assign doneExc    = md_resultRDY ? md_exception : 1'b1;
  assign skipCommit = md_resultRDY && !md_exception && (destReg == 5'd0);

  assign wb_req = (state == COMMIT);
  assign busy   = (state != IDLE);

  always_comb begin
    nextState    = state;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        stall        = 1'b1;
        md_ctrl_mult = !opIsDiv;
        md_ctrl_div  = opIsDiv;
        nextState    = WAIT;
      end
      WAIT: begin
        stall = !skipCommit;
        if (waitDone) begin
          nextState = skipCommit ? IDLE : COMMIT;
        end
      end
      COMMIT: begin
        stall = !wb_grant;
        if (wb_grant) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      md_operandA <= 32'd0;
      md_operandB <= 32'd0;
      destReg     <= 5'd0;
      opIsDiv     <= 1'b0;
      waitCount   <= 8'd0;
      wb_reg      <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      state <= nextState;
      if (state == IDLE && accept) begin
        md_operandA <= op_a;
        md_operandB <= op_b;
        destReg     <= insn_dx[26:22];
        opIsDiv     <= isDiv;
        waitCount   <= 8'd0;
      end
      if (state == WAIT) begin
        if (waitCount != 8'hFF) begin
          waitCount <= waitCount + 8'd1;
        end
        // wb_reg/wb_data are loaded once here and held through COMMIT.
        if (waitDone && !skipCommit) begin
          if (doneExc) begin
            wb_reg  <= 5'(RSTATUS_REG);
            wb_data <= opIsDiv ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
          end else begin
            wb_reg  <= destReg;
            wb_data <= md_result;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: directed and randomized mul/div operations, each
// checked cycle by cycle against a timeline derived from the operation's parameters.
module tb_multdiv_sequencer;

  localparam int TMO = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [31:0] insn_dx;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_req;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_grant;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  multdiv_sequencer #(
    .RSTATUS_REG(30), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .insn_dx(insn_dx),
    .op_a(op_a), .op_b(op_b), .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_result(md_result),
    .md_exception(md_exception), .md_resultRDY(md_resultRDY), .stall(stall),
    .wb_req(wb_req), .wb_reg(wb_reg), .wb_data(wb_data), .wb_grant(wb_grant), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic quiet_inputs();
    issue_valid  = 1'b0;
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    wb_grant     = 1'b0;
  endtask

  // One mul/div from accept to the end of its commit (or skip). lat is the WAIT cycle
  // (1-based) in which the unit reports ready; lat > TMO means it never does in time.
  task automatic run_op(input bit isDivOp, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] res,
                        input bit exc, input int grantWait);
    logic [31:0] rnd, insn, expData;
    logic [4:0]  expReg, expCtl, gotCtl;
    bit          timeoutHit, excEff, commit, expStall;
    int          lc, lastK, j;
    rnd        = $urandom();
    insn       = {5'd0, rd, rnd[21:7], (isDivOp ? 5'd7 : 5'd6), rnd[1:0]};
    timeoutHit = (lat > TMO);
    lc         = timeoutHit ? TMO : lat;
    excEff     = timeoutHit || exc;
    commit     = excEff || (rd != 5'd0);
    expReg     = excEff ? 5'd30 : rd;
    expData    = excEff ? (isDivOp ? 32'd5 : 32'd4) : res;
    lastK      = commit ? (2 + lc + grantWait) : (1 + lc);
    for (int k = 0; k <= lastK; k++) begin
      j           = k - (2 + lc);
      issue_valid = 1'b1;
      insn_dx     = insn;
      op_a        = (k == 0) ? a : $urandom();
      op_b        = (k == 0) ? b : $urandom();
      if (k >= 2 && k <= 1 + lc) begin
        md_resultRDY = !timeoutHit && (k == 1 + lat);
        md_exception = md_resultRDY ? exc : 1'($urandom_range(0, 1));
        md_result    = md_resultRDY ? res : $urandom();
      end else begin
        md_resultRDY = 1'($urandom_range(0, 1));
        md_exception = 1'($urandom_range(0, 1));
        md_result    = $urandom();
      end
      wb_grant = (commit && j >= 0) ? (j == grantWait) : 1'($urandom_range(0, 1));
      @(negedge clock);
      if (k <= 1 + lc) expStall = !(k == 1 + lc && !commit);
      else             expStall = (j != grantWait);
      expCtl = {expStall, k != 0, k == 1 && !isDivOp, k == 1 && isDivOp, commit && k >= 2 + lc};
      gotCtl = {stall, busy, md_ctrl_mult, md_ctrl_div, wb_req};
      vectors++;
      if (gotCtl !== expCtl) begin
        $display("FAIL op_ctl k=%0d {stall,busy,mult,div,req} got %b expected %b", k, gotCtl, expCtl);
        miscompares++;
      end
      if (k >= 1) begin
        vectors++;
        if ({md_operandA, md_operandB} !== {a, b}) begin
          $display("FAIL op_operands k=%0d got %h/%h expected %h/%h", k, md_operandA, md_operandB, a, b);
          miscompares++;
        end
      end
      if (commit && k >= 2 + lc) begin
        vectors++;
        if ({wb_reg, wb_data} !== {expReg, expData}) begin
          $display("FAIL op_wb k=%0d got reg %0d data %h expected reg %0d data %h", k, wb_reg, wb_data, expReg, expData);
          miscompares++;
        end
      end
      @(posedge clock); #1;
    end
    quiet_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    quiet_inputs();
    insn_dx = 32'd0; op_a = 32'd0; op_b = 32'd0; md_result = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    vectors++;
    if ({stall, busy, md_ctrl_mult, md_ctrl_div, wb_req, wb_reg, wb_data, md_operandA, md_operandB} !== '0) begin
      $display("FAIL reset_state got stall=%b busy=%b mult=%b div=%b req=%b reg=%0d data=%h A=%h B=%h",
               stall, busy, md_ctrl_mult, md_ctrl_div, wb_req, wb_reg, wb_data, md_operandA, md_operandB);
      miscompares++;
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_idle_check(input int cycles);
    quiet_inputs();
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      vectors++;
      if ({stall, busy, wb_req, md_ctrl_mult, md_ctrl_div} !== 5'b0) begin
        $display("FAIL idle_outputs got stall=%b busy=%b req=%b mult=%b div=%b expected all 0",
                 stall, busy, wb_req, md_ctrl_mult, md_ctrl_div);
        miscompares++;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_non_md();
    logic [31:0] insns [3];
    insns[0] = {5'd0, 5'd4, 15'h1234, 5'd5, 2'b11};
    insns[1] = {5'd1, 5'd4, 15'h0000, 5'd6, 2'b00};
    insns[2] = {5'd2, 5'd9, 15'h7fff, 5'd7, 2'b01};
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      insn_dx     = insns[i];
      @(negedge clock);
      vectors++;
      if ({stall, busy} !== 2'b00) begin
        $display("FAIL non_md insn=%h got stall=%b busy=%b expected 0 0", insns[i], stall, busy);
        miscompares++;
      end
      @(posedge clock); #1;
    end
    test_idle_check(1);
  endtask

  task automatic test_mul_basic();
    run_op(1'b0, 5'd5, 32'd6, 32'd7, 16, 32'd42, 1'b0, 0);
    test_idle_check(1);
  endtask

  task automatic test_div_exception();
    run_op(1'b1, 5'd3, $urandom(), 32'd0, 5, $urandom(), 1'b1, 1);
    run_op(1'b0, 5'd9, 32'h4000_0000, 32'd4, 8, 32'd0, 1'b1, 0);
    test_idle_check(1);
  endtask

  task automatic test_skip_commit();
    run_op(1'b0, 5'd0, 32'd11, 32'd13, 4, 32'd143, 1'b0, 0);
    test_idle_check(2);
  endtask

  task automatic test_grant_wait();
    run_op(1'b1, 5'd12, 32'd100, 32'd7, 3, 32'd14, 1'b0, 3);
    test_idle_check(1);
  endtask

  task automatic test_timeout();
    run_op(1'b0, 5'd7, $urandom(), $urandom(), TMO + 10, $urandom(), 1'b0, 0);
    run_op(1'b1, 5'd0, $urandom(), $urandom(), TMO + 1, $urandom(), 1'b0, 2);
    // Ready in the very cycle the timeout would fire: the real result commits.
    run_op(1'b0, 5'd17, $urandom(), $urandom(), TMO, 32'hCAFE_F00D, 1'b0, 1);
    test_idle_check(1);
  endtask

  task automatic test_back_to_back();
    run_op(1'b0, 5'd1, 32'd3, 32'd5, 1, 32'd15, 1'b0, 0);
    run_op(1'b1, 5'd2, 32'd20, 32'd4, 2, 32'd5, 1'b0, 0);
    run_op(1'b0, 5'd0, 32'd2, 32'd2, 1, 32'd4, 1'b0, 0);
    run_op(1'b1, 5'd6, 32'd9, 32'd0, 1, 32'd0, 1'b1, 0);
    test_idle_check(1);
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1;
    insn_dx     = {5'd0, 5'd4, 15'd0, 5'd6, 2'b00};
    op_a        = 32'hDEAD_BEEF;
    op_b        = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) reset = 1'b1;
      @(posedge clock); #1;
    end
    reset        = 1'b0;
    issue_valid  = 1'b0;
    md_resultRDY = 1'b1;
    md_result    = 32'h5555_AAAA;
    wb_grant     = 1'b1;
    @(negedge clock);
    vectors++;
    if ({stall, busy, md_ctrl_mult, md_ctrl_div, wb_req, wb_reg, wb_data, md_operandA, md_operandB} !== '0) begin
      $display("FAIL reset_mid got stall=%b busy=%b mult=%b div=%b req=%b reg=%0d data=%h A=%h B=%h expected all 0",
               stall, busy, md_ctrl_mult, md_ctrl_div, wb_req, wb_reg, wb_data, md_operandA, md_operandB);
      miscompares++;
    end
    @(posedge clock); #1;
    md_resultRDY = 1'b1;
    @(posedge clock); #1;
    test_idle_check(3);
  endtask

  task automatic test_random(input int nOps);
    logic [4:0] rd;
    for (int n = 0; n < nOps; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(1'($urandom_range(0, 1)), rd, $urandom(), $urandom(), $urandom_range(1, TMO + 4),
             $urandom(), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) test_idle_check(1);
    end
  endtask

  initial begin
    test_reset();
    test_non_md();
    test_mul_basic();
    test_div_exception();
    test_skip_commit();
    test_grant_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
